// File: rtl/timer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : timer_pkg
// Desc     : Shared types and constants for the round countdown controller.
// Revision : 1.0  initial release
// ============================================================================
package timer_pkg;

  localparam int DEF_CNT_W           = 8;
  localparam int DEF_TICKS_PER_TENTH = 100;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    PAUSE   = 2'd2,
    EXPIRED = 2'd3
  } round_state_t;

  // A divide-by-one prescaler still needs a one-bit counter to be legal.
  function automatic int presc_width(input int ticks);
    return (ticks > 1) ? $clog2(ticks) : 1;
  endfunction

  localparam int PRESC_W = presc_width(DEF_TICKS_PER_TENTH);

endpackage
`default_nettype wire

// File: rtl/tick_div.sv
`default_nettype none
// ============================================================================
// Module   : tick_div
// Desc     : 1 ms -> tenth-of-second prescaler with clear and enable.
// Revision : 1.0  initial release
// ============================================================================
module tick_div
  import timer_pkg::*;
#(
  parameter int TICKS_PER_TENTH = DEF_TICKS_PER_TENTH
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  input  logic tick_1ms,
  output logic tick_tenth
);

  localparam int              W    = presc_width(TICKS_PER_TENTH);
  localparam logic [W-1:0]    LAST = W'(TICKS_PER_TENTH - 1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;
  logic         at_last;
  logic         adv;

  assign at_last    = (cnt_q == LAST);
  assign adv        = en & tick_1ms & ~clr;
  assign tick_tenth = adv & at_last;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (adv) begin
      cnt_d = at_last ? '0 : cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/round_timer_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : round_timer_ctrl
// Desc     : Round countdown FSM with pause/resume/abort and registered status.
// Revision : 1.0  initial release
// ============================================================================
module round_timer_ctrl
  import timer_pkg::*;
#(
  parameter int ROUND_TENTHS    = 100,
  parameter int WARN_TENTHS     = 30,
  parameter int TICKS_PER_TENTH = DEF_TICKS_PER_TENTH,
  parameter int CNT_W           = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick_1ms,
  input  logic             start,
  input  logic             pause,
  input  logic             resume,
  input  logic             abort,
  input  logic [CNT_W-1:0] limit_tenths,
  output logic             busy,
  output logic             paused,
  output logic [CNT_W-1:0] time_left,
  output logic             warn,
  output logic             expired
);

  localparam logic [CNT_W-1:0] DEFAULT_LIMIT = CNT_W'(ROUND_TENTHS);
  localparam logic [CNT_W-1:0] WARN_LEVEL    = CNT_W'(WARN_TENTHS);

  round_state_t     state_q, state_d;
  logic [CNT_W-1:0] time_left_q, time_left_d;
  logic             busy_q, busy_d;
  logic             paused_q, paused_d;
  logic             warn_q, warn_d;
  logic             expired_q, expired_d;

  logic             presc_clr;
  logic             presc_en;
  logic             tick_tenth;

  // Abort and start both restart the tenth boundary; pause swallows a same-cycle tick.
  assign presc_clr = abort | start;
  assign presc_en  = (state_q == RUN) & ~pause;

  tick_div #(
    .TICKS_PER_TENTH(TICKS_PER_TENTH)
  ) u_tick_div (
    .clk       (clk),
    .rst       (rst),
    .clr       (presc_clr),
    .en        (presc_en),
    .tick_1ms  (tick_1ms),
    .tick_tenth(tick_tenth)
  );

  always_comb begin
    state_d     = state_q;
    time_left_d = time_left_q;
    expired_d   = 1'b0;

    if (abort) begin
      state_d     = IDLE;
      time_left_d = '0;
    end else if (start) begin
      state_d     = RUN;
      time_left_d = (limit_tenths == '0) ? DEFAULT_LIMIT : limit_tenths;
    end else begin
      case (state_q)
        RUN: begin
          if (pause) begin
            state_d = PAUSE;
          end else if (tick_tenth) begin
            if (time_left_q > CNT_W'(1)) begin
              time_left_d = time_left_q - CNT_W'(1);
            end else begin
              time_left_d = '0;
              state_d     = EXPIRED;
              expired_d   = 1'b1;
            end
          end
        end
        PAUSE: begin
          if (resume) begin
            state_d = RUN;
          end
        end
        default: begin
          state_d = state_q;
        end
      endcase
    end

    busy_d   = (state_d == RUN) || (state_d == PAUSE);
    paused_d = (state_d == PAUSE);
    warn_d   = busy_d && (time_left_d <= WARN_LEVEL) && (time_left_d != '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      time_left_q <= '0;
      busy_q      <= 1'b0;
      paused_q    <= 1'b0;
      warn_q      <= 1'b0;
      expired_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      time_left_q <= time_left_d;
      busy_q      <= busy_d;
      paused_q    <= paused_d;
      warn_q      <= warn_d;
      expired_q   <= expired_d;
    end
  end

  assign busy      = busy_q;
  assign paused    = paused_q;
  assign time_left = time_left_q;
  assign warn      = warn_q;
  assign expired   = expired_q;

endmodule
`default_nettype wire

// File: tb/tb_round_timer_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_round_timer_ctrl
// Desc     : Scoreboard bench for round_timer_ctrl against a tick-count model.
// Revision : 1.0  initial release
// ============================================================================
module tb_round_timer_ctrl;

  localparam int TPT  = 4;
  localparam int WARN = 2;
  localparam int RND  = 5;

  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_PAUSE = 2;
  localparam int M_EXP   = 3;

  logic       clk = 1'b0;
  logic       rst, tick_1ms, start, pause, resume, abort;
  logic [7:0] limit_tenths;
  logic       busy, paused, warn, expired;
  logic [7:0] time_left;

  always #5 clk = ~clk;

  round_timer_ctrl #(
    .ROUND_TENTHS   (RND),
    .WARN_TENTHS    (WARN),
    .TICKS_PER_TENTH(TPT),
    .CNT_W          (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .tick_1ms    (tick_1ms),
    .start       (start),
    .pause       (pause),
    .resume      (resume),
    .abort       (abort),
    .limit_tenths(limit_tenths),
    .busy        (busy),
    .paused      (paused),
    .time_left   (time_left),
    .warn        (warn),
    .expired     (expired)
  );

  typedef struct packed {
    logic       busy;
    logic       paused;
    logic [7:0] tl;
    logic       warn;
    logic       expired;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;

  // Model: a round is the count of accepted ticks; time left is limit minus whole tenths elapsed.
  int m_mode = M_IDLE;
  int m_acc  = 0;
  int m_lim  = 0;

  task automatic drive(input bit r, input bit a, input bit s, input bit p,
                       input bit u, input bit tk, input int lim);
    exp_t e;
    bit   fired;
    int   left;
    fired        = 1'b0;
    rst          = r;
    abort        = a;
    start        = s;
    pause        = p;
    resume       = u;
    tick_1ms     = tk;
    limit_tenths = 8'(lim);
    if (r || a) begin
      m_mode = M_IDLE; m_acc = 0; m_lim = 0;
    end else if (s) begin
      m_mode = M_RUN; m_acc = 0; m_lim = (lim == 0) ? RND : lim;
    end else if (m_mode == M_RUN && p) begin
      m_mode = M_PAUSE;
    end else if (m_mode == M_PAUSE && u) begin
      m_mode = M_RUN;
    end else if (m_mode == M_RUN && tk) begin
      m_acc++;
      if (m_acc / TPT >= m_lim) begin
        m_mode = M_EXP;
        fired  = 1'b1;
      end
    end
    left      = (m_mode == M_IDLE || m_mode == M_EXP) ? 0 : m_lim - m_acc / TPT;
    e.busy    = (m_mode == M_RUN) || (m_mode == M_PAUSE);
    e.paused  = (m_mode == M_PAUSE);
    e.tl      = 8'(left);
    e.warn    = e.busy && (left <= WARN) && (left != 0);
    e.expired = fired;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic tk();
    drive(0, 0, 0, 0, 0, 1, 0);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      n_tests++;
      if ({busy, paused, time_left, warn, expired} !== mon_e) begin
        n_fail++;
        $display("FAIL outputs cyc %0d: got busy=%b paused=%b time_left=%0d warn=%b expired=%b, want busy=%b paused=%b time_left=%0d warn=%b expired=%b",
                 cyc, busy, paused, time_left, warn, expired,
                 mon_e.busy, mon_e.paused, mon_e.tl, mon_e.warn, mon_e.expired);
      end
    end
    cyc++;
  end

  initial begin
    drive(1, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 1, 0);
    idle(1);

    // Basic countdown from 3, one tick every 3 cycles, then ignored commands in EXPIRED.
    drive(0, 0, 1, 0, 0, 1, 3);
    repeat (12) begin tk(); idle(2); end
    repeat (5) tk();
    drive(0, 0, 0, 1, 0, 0, 0);
    drive(0, 0, 0, 0, 1, 1, 0);

    // Default limit, then pause while IDLE.
    drive(0, 0, 1, 0, 0, 0, 0);
    idle(2);
    drive(0, 1, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 1, 0, 0, 0);
    idle(1);

    // Pause and resume keep the prescaler phase.
    drive(0, 0, 1, 0, 0, 0, 2);
    tk(); tk();
    drive(0, 0, 0, 1, 0, 1, 0);
    repeat (10) tk();
    drive(0, 0, 0, 0, 1, 0, 0);
    repeat (7) tk();

    // Abort together with the final tick.
    drive(0, 0, 1, 0, 0, 0, 1);
    repeat (3) tk();
    drive(0, 1, 0, 0, 0, 1, 0);
    idle(1);

    // Start together with the final tick, then resume while running.
    drive(0, 0, 1, 0, 0, 0, 1);
    repeat (3) tk();
    drive(0, 0, 1, 0, 0, 1, 4);
    idle(1);
    drive(0, 0, 0, 0, 1, 1, 0);
    repeat (3) tk();

    // Reset in RUN at time_left 2.
    drive(0, 0, 1, 0, 0, 0, 3);
    repeat (4) tk();
    drive(1, 0, 0, 0, 0, 1, 0);
    repeat (6) tk();

    repeat (3000) begin
      drive($urandom_range(0, 399) == 0,
            $urandom_range(0, 149) == 0,
            $urandom_range(0, 59)  == 0,
            $urandom_range(0, 24)  == 0,
            $urandom_range(0, 14)  == 0,
            $urandom_range(0, 2)   == 0,
            int'($urandom_range(0, 6)));
    end
    idle(1);

    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d expected entries left, want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
